// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - mode constants and default width for the T flip-flop counter bank
package tff_pkg;

  localparam int   DEFAULT_WIDTH = 8;
  localparam logic MODE_TOGGLE   = 1'b0;
  localparam logic MODE_COUNT    = 1'b1;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with synchronous reset value and parallel load
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic load,
  input  logic d,
  input  logic tgl,
  output logic q
);

  logic q_q;
  logic q_d;

  // Load beats toggle; with neither the bit holds.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (tgl) begin
      q_d = ~q_q;
    end
  end

  // State register; reset overrides load and toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_counter_bank.sv
// rtl/tff_counter_bank.sv - bank of T flip-flops acting as toggle register or up/down counter; TFF_COUNTER_BANK_IRQ_EN adds a sticky wrap interrupt
module tff_counter_bank
  import tff_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] t,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`ifdef TFF_COUNTER_BANK_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] tgl;

  // Carry (up) / borrow (down) chain: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic ones;
    logic zeros;
    chain = '0;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      chain[i] = up ? ones : zeros;
      ones     = ones & q[i];
      zeros    = zeros & ~q[i];
    end
  end

  // Per-bit toggle enable: counter chain or raw mask, gated by en.
  always_comb begin
    tgl = '0;
    if (en) begin
      tgl = (mode == MODE_COUNT) ? chain : t;
    end
  end

  // Terminal count looks at the registered value only, so mode/up changes show immediately.
  always_comb begin
    tc = 1'b0;
    if (mode == MODE_COUNT) begin
      tc = up ? (&q) : ~(|q);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .load    (load),
      .d       (d[i]),
      .tgl     (tgl[i]),
      .q       (q[i])
    );
  end

`ifdef TFF_COUNTER_BANK_IRQ_EN
  logic irq_q;
  logic irq_d;

  // Sticky wrap flag: clear first so a coincident wrap wins.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) begin
      irq_d = 1'b0;
    end
    if ((mode == MODE_COUNT) && en && !load && tc) begin
      irq_d = 1'b1;
    end
  end

  // Interrupt register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule : tff_counter_bank

// File: tb/tb_tff_counter_bank.sv
// tb/tb_tff_counter_bank.sv - directed self-checking bench for tff_counter_bank (WIDTH=8, RESET_VAL=0)
module tb_tff_counter_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [7:0] t;
  logic       up;
  logic       load;
  logic [7:0] d;
  logic [7:0] q;
  logic       tc;
`ifdef TFF_COUNTER_BANK_IRQ_EN
  logic       irq_clr;
  logic       irq;
`endif

  int vec_cnt;
  int err_cnt;

  tff_counter_bank #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .t       (t),
    .up      (up),
    .load    (load),
    .d       (d),
`ifdef TFF_COUNTER_BANK_IRQ_EN
    .irq_clr (irq_clr),
    .irq     (irq),
`endif
    .q       (q),
    .tc      (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst  = 1'b1;
    en   = 1'b1;
    mode = 1'b0;
    t    = 8'h00;
    up   = 1'b1;
    load = 1'b1;
    d    = 8'hFF;
`ifdef TFF_COUNTER_BANK_IRQ_EN
    irq_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_q", 32'(q), 32'h00);
    check("rst_tc", 32'(tc), 32'h0);
`ifdef TFF_COUNTER_BANK_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif

    // toggle mode
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b1;
    t    = 8'hA5;
    tick();
    check("tgl_a5", 32'(q), 32'hA5);
    tick();
    check("tgl_00", 32'(q), 32'h00);
    en = 1'b0;
    t  = 8'hFF;
    tick();
    check("tgl_hold_en0", 32'(q), 32'h00);
    t  = 8'h3C;
    en = 1'b1;
    tick();
    check("tgl_3c", 32'(q), 32'h3C);
    t = 8'h00;
    tick();
    check("tgl_t0_hold", 32'(q), 32'h3C);
    check("tgl_tc", 32'(tc), 32'h0);

    // count up through wrap
    en   = 1'b0;
    mode = 1'b1;
    check("mode_sw_no_q", 32'(q), 32'h3C);
    up   = 1'b1;
    load = 1'b1;
    d    = 8'hFD;
    tick();
    check("ld_fd", 32'(q), 32'hFD);
    load = 1'b0;
    en   = 1'b1;
    t    = 8'hFF;
    tick();
    check("up_fe", 32'(q), 32'hFE);
    check("up_fe_tc", 32'(tc), 32'h0);
    tick();
    check("up_ff", 32'(q), 32'hFF);
    check("up_ff_tc", 32'(tc), 32'h1);
`ifdef TFF_COUNTER_BANK_IRQ_EN
    check("pre_wrap_irq", 32'(irq), 32'h0);
`endif
    tick();
    check("up_wrap", 32'(q), 32'h00);
    check("up_wrap_tc", 32'(tc), 32'h0);
`ifdef TFF_COUNTER_BANK_IRQ_EN
    check("wrap_irq", 32'(irq), 32'h1);
`endif

    // count down through wrap, then reverse
    en   = 1'b0;
    up   = 1'b0;
    load = 1'b1;
    d    = 8'h01;
    tick();
    check("ld_01", 32'(q), 32'h01);
    load = 1'b0;
    en   = 1'b1;
    tick();
    check("dn_00", 32'(q), 32'h00);
    check("dn_00_tc", 32'(tc), 32'h1);
    tick();
    check("dn_ff", 32'(q), 32'hFF);
    check("dn_ff_tc", 32'(tc), 32'h0);
    up = 1'b1;
    #1;
    check("dir_sw_tc", 32'(tc), 32'h1);
    check("dir_sw_q", 32'(q), 32'hFF);
    tick();
    check("dir_sw_wrap", 32'(q), 32'h00);
    tick();
    check("up_01", 32'(q), 32'h01);

    // load priority and mid-count reset
    load = 1'b1;
    d    = 8'h3C;
    tick();
    check("ld_wins", 32'(q), 32'h3C);
    d = 8'h57;
    tick();
    check("ld_57", 32'(q), 32'h57);
    load = 1'b0;
    rst  = 1'b1;
    tick();
    check("rst_mid", 32'(q), 32'h00);
    check("rst_mid_tc", 32'(tc), 32'h0);
`ifdef TFF_COUNTER_BANK_IRQ_EN
    check("rst_mid_irq", 32'(irq), 32'h0);
`endif
    rst = 1'b0;
    tick();
    check("post_rst_cnt", 32'(q), 32'h01);

`ifdef TFF_COUNTER_BANK_IRQ_EN
    // set/clear coincidence and plain clear
    en   = 1'b0;
    load = 1'b1;
    d    = 8'hFF;
    tick();
    load    = 1'b0;
    en      = 1'b1;
    irq_clr = 1'b1;
    tick();
    check("clr_wrap_q", 32'(q), 32'h00);
    check("clr_wrap_irq", 32'(irq), 32'h1);
    en = 1'b0;
    tick();
    check("clr_alone_irq", 32'(irq), 32'h0);
    irq_clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_tff_counter_bank
